// File: rtl/obi_rr_arbiter.sv
// 2-to-1 round-robin OBI arbiter with address-phase locking and in-order response routing.
// Optional OBI_RR_ARBITER_ERR_EN adds a sticky protocol-violation flag on err_o.
package obi_rr_arbiter_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
    } obi_resp_t;
endpackage

module obi_rr_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter type obi_req_t  = obi_rr_arbiter_pkg::obi_req_t,
    parameter type obi_resp_t = obi_rr_arbiter_pkg::obi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  m0_obi_req_i,
    output obi_resp_t m0_obi_resp_o,
    input  obi_req_t  m1_obi_req_i,
    output obi_resp_t m1_obi_resp_o,
    output obi_req_t  obi_req_o,
    input  obi_resp_t obi_resp_i
`ifdef OBI_RR_ARBITER_ERR_EN
    ,
    output logic      err_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    logic                       rr_q, rr_d;
    logic                       lock_q, lock_d;
    logic                       lock_sel_q, lock_sel_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] mem_q, mem_d;

    logic sel;
    logic full;
    logic fwd_req;
    logic hs;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Master selection: a stalled address phase keeps its owner, otherwise round-robin
    always_comb begin
        sel = rr_q;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (m0_obi_req_i.req && !m1_obi_req_i.req) begin
            sel = 1'b0;
        end else if (m1_obi_req_i.req && !m0_obi_req_i.req) begin
            sel = 1'b1;
        end
    end

    assign full    = (cnt_q == CNT_FULL);
    assign fwd_req = (sel ? m1_obi_req_i.req : m0_obi_req_i.req) & ~full;
    assign hs      = fwd_req & obi_resp_i.gnt;
    assign pop     = obi_resp_i.rvalid & (cnt_q != '0);
    assign head    = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_q      <= mem_d;
        end
    end

    // Next state: lock tracking, round-robin pointer and response-routing FIFO
    always_comb begin
        rr_d       = rr_q;
        lock_d     = fwd_req & ~obi_resp_i.gnt;
        lock_sel_d = sel;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_d      = mem_q;
        if (hs) begin
            rr_d          = ~sel;
            mem_d[wptr_q] = sel;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        obi_req_o              = sel ? m1_obi_req_i : m0_obi_req_i;
        obi_req_o.req          = fwd_req;
        m0_obi_resp_o          = '0;
        m1_obi_resp_o          = '0;
        m0_obi_resp_o.rdata    = obi_resp_i.rdata;
        m1_obi_resp_o.rdata    = obi_resp_i.rdata;
        m0_obi_resp_o.gnt      = hs & ~sel;
        m1_obi_resp_o.gnt      = hs & sel;
        m0_obi_resp_o.rvalid   = pop & ~head;
        m1_obi_resp_o.rvalid   = pop & head;
    end

`ifdef OBI_RR_ARBITER_ERR_EN
    logic err_q, err_d;

    // Sticky: orphan rvalid, or a grant with nothing being requested
    assign err_d = err_q
                 | (obi_resp_i.rvalid & (cnt_q == '0))
                 | (obi_resp_i.gnt & ~fwd_req);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule
